// File: rtl/coreriscv_axi4_grant_serializer.sv
// Grant-channel serializer: splits one wide grant beat into RATIO narrow sub-beats,
// low slice first. RATIO=1 builds as a stateless flow-through.
module coreriscv_axi4_grant_serializer #(
    parameter int unsigned IN_DATA_W = 64,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned BEAT_W    = 3,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned MGR_ID_W  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        io_in_ready,
    input  logic                        io_in_valid,
    input  logic [BEAT_W-1:0]           io_in_bits_addr_beat,
    input  logic                        io_in_bits_client_xact_id,
    input  logic [MGR_ID_W-1:0]         io_in_bits_manager_xact_id,
    input  logic                        io_in_bits_is_builtin_type,
    input  logic [3:0]                  io_in_bits_g_type,
    input  logic                        io_in_bits_has_data,
    input  logic [IN_DATA_W-1:0]        io_in_bits_data,
    input  logic                        io_out_ready,
    output logic                        io_out_valid,
    output logic [BEAT_W+CNT_W-1:0]     io_out_bits_addr_beat,
    output logic                        io_out_bits_client_xact_id,
    output logic [MGR_ID_W-1:0]         io_out_bits_manager_xact_id,
    output logic                        io_out_bits_is_builtin_type,
    output logic [3:0]                  io_out_bits_g_type,
    output logic [IN_DATA_W/RATIO-1:0]  io_out_bits_data,
    output logic [CNT_W-1:0]            io_cnt,
    output logic                        io_done
);

    localparam int unsigned OutW = IN_DATA_W / RATIO;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    if (RATIO == 1) begin : g_flow
        // No buffering: every field passes straight through.
        assign io_in_ready                 = io_out_ready;
        assign io_out_valid                = io_in_valid;
        assign io_out_bits_addr_beat       = {io_in_bits_addr_beat, {CNT_W{1'b0}}};
        assign io_out_bits_client_xact_id  = io_in_bits_client_xact_id;
        assign io_out_bits_manager_xact_id = io_in_bits_manager_xact_id;
        assign io_out_bits_is_builtin_type = io_in_bits_is_builtin_type;
        assign io_out_bits_g_type          = io_in_bits_g_type;
        assign io_out_bits_data            = io_in_bits_data;
        assign io_cnt                      = '0;
        assign io_done                     = 1'b1;
    end else begin : g_ser
        state_e                        state_q, state_d;
        logic [CNT_W-1:0]              cnt_q, cnt_d;
        logic [BEAT_W-1:0]             hold_addr_q;
        logic                          hold_cid_q;
        logic [MGR_ID_W-1:0]           hold_mid_q;
        logic                          hold_builtin_q;
        logic [3:0]                    hold_gtype_q;
        logic                          hold_has_data_q;
        logic [IN_DATA_W-1:0]          hold_data_q;

        logic                          busy;
        logic                          capture;
        logic [CNT_W-1:0]              last_cnt;
        logic [RATIO-1:0][OutW-1:0]    slices;

        assign busy     = (state_q == StBusy);
        // Non-data grants are a single ack beat.
        assign last_cnt = hold_has_data_q ? CNT_W'(RATIO - 1) : '0;
        assign io_done  = busy && io_out_ready && (cnt_q == last_cnt);
        // Accepting on the final sub-beat lets bursts run back to back.
        assign io_in_ready = !busy || io_done;
        assign capture     = io_in_valid && io_in_ready;

        assign slices                      = hold_data_q;
        assign io_out_valid                = busy;
        assign io_cnt                      = cnt_q;
        assign io_out_bits_addr_beat       = {hold_addr_q, cnt_q};
        assign io_out_bits_client_xact_id  = hold_cid_q;
        assign io_out_bits_manager_xact_id = hold_mid_q;
        assign io_out_bits_is_builtin_type = hold_builtin_q;
        assign io_out_bits_g_type          = hold_gtype_q;
        assign io_out_bits_data            = slices[cnt_q];

        // Next state: capture restarts the count, done retires, handshake advances.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (capture) begin
                state_d = StBusy;
                cnt_d   = '0;
            end else if (io_done) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else if (busy && io_out_ready) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // State, sub-beat counter and holding register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q         <= StIdle;
                cnt_q           <= '0;
                hold_addr_q     <= '0;
                hold_cid_q      <= 1'b0;
                hold_mid_q      <= '0;
                hold_builtin_q  <= 1'b0;
                hold_gtype_q    <= '0;
                hold_has_data_q <= 1'b0;
                hold_data_q     <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (capture) begin
                    hold_addr_q     <= io_in_bits_addr_beat;
                    hold_cid_q      <= io_in_bits_client_xact_id;
                    hold_mid_q      <= io_in_bits_manager_xact_id;
                    hold_builtin_q  <= io_in_bits_is_builtin_type;
                    hold_gtype_q    <= io_in_bits_g_type;
                    hold_has_data_q <= io_in_bits_has_data;
                    hold_data_q     <= io_in_bits_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_coreriscv_axi4_grant_serializer.sv
// Bench for the grant serializer: queue-of-beats model checked every cycle,
// plus directed literal checks, plus a RATIO=1 flow-through instance.
module tb_coreriscv_axi4_grant_serializer;

    localparam int IN_W   = 64;
    localparam int RATIO  = 4;
    localparam int BEAT_W = 3;
    localparam int CNT_W  = 2;
    localparam int MGR_W  = 2;
    localparam int OUT_W  = IN_W / RATIO;

    logic clk;
    logic reset;
    logic in_valid, in_cid, in_bi, in_hd;
    logic [BEAT_W-1:0] in_ab;
    logic [MGR_W-1:0]  in_mid;
    logic [3:0]        in_gt;
    logic [IN_W-1:0]   in_data;
    logic out_ready;

    logic in_ready, out_valid, out_cid, out_bi, done;
    logic [BEAT_W+CNT_W-1:0] out_ab;
    logic [MGR_W-1:0]        out_mid;
    logic [3:0]              out_gt;
    logic [OUT_W-1:0]        out_data;
    logic [CNT_W-1:0]        cnt;

    logic r1_out_ready;
    logic r1_in_ready, r1_out_valid, r1_cid, r1_bi, r1_done;
    logic [BEAT_W:0]   r1_ab;
    logic [MGR_W-1:0]  r1_mid;
    logic [3:0]        r1_gt;
    logic [IN_W-1:0]   r1_data;
    logic [0:0]        r1_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    coreriscv_axi4_grant_serializer #(
        .IN_DATA_W(IN_W), .RATIO(RATIO), .BEAT_W(BEAT_W), .CNT_W(CNT_W), .MGR_ID_W(MGR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .io_in_ready(in_ready), .io_in_valid(in_valid),
        .io_in_bits_addr_beat(in_ab), .io_in_bits_client_xact_id(in_cid),
        .io_in_bits_manager_xact_id(in_mid), .io_in_bits_is_builtin_type(in_bi),
        .io_in_bits_g_type(in_gt), .io_in_bits_has_data(in_hd), .io_in_bits_data(in_data),
        .io_out_ready(out_ready), .io_out_valid(out_valid),
        .io_out_bits_addr_beat(out_ab), .io_out_bits_client_xact_id(out_cid),
        .io_out_bits_manager_xact_id(out_mid), .io_out_bits_is_builtin_type(out_bi),
        .io_out_bits_g_type(out_gt), .io_out_bits_data(out_data),
        .io_cnt(cnt), .io_done(done)
    );

    coreriscv_axi4_grant_serializer #(
        .IN_DATA_W(IN_W), .RATIO(1), .BEAT_W(BEAT_W), .CNT_W(1), .MGR_ID_W(MGR_W)
    ) dut_r1 (
        .clk(clk), .reset(reset),
        .io_in_ready(r1_in_ready), .io_in_valid(in_valid),
        .io_in_bits_addr_beat(in_ab), .io_in_bits_client_xact_id(in_cid),
        .io_in_bits_manager_xact_id(in_mid), .io_in_bits_is_builtin_type(in_bi),
        .io_in_bits_g_type(in_gt), .io_in_bits_has_data(in_hd), .io_in_bits_data(in_data),
        .io_out_ready(r1_out_ready), .io_out_valid(r1_out_valid),
        .io_out_bits_addr_beat(r1_ab), .io_out_bits_client_xact_id(r1_cid),
        .io_out_bits_manager_xact_id(r1_mid), .io_out_bits_is_builtin_type(r1_bi),
        .io_out_bits_g_type(r1_gt), .io_out_bits_data(r1_data),
        .io_cnt(r1_cnt), .io_done(r1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a queue of the sub-beats still owed downstream.
    typedef struct {
        logic [BEAT_W+CNT_W-1:0] ab;
        logic [OUT_W-1:0]        data;
        logic [CNT_W-1:0]        cnt;
        logic                    last;
        logic                    cid;
        logic [MGR_W-1:0]        mid;
        logic                    bi;
        logic [3:0]              gt;
    } beat_t;

    beat_t exp_q[$];
    beat_t nb;
    logic  m_busy, m_done, m_rdy;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_cnt", 64'(cnt), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
        end else begin
            m_busy = exp_q.size() > 0;
            m_done = m_busy && out_ready && exp_q[0].last;
            m_rdy  = !m_busy || m_done;
            chk("m_out_valid", 64'(out_valid), 64'(m_busy));
            chk("m_in_ready", 64'(in_ready), 64'(m_rdy));
            chk("m_done", 64'(done), 64'(m_done));
            chk("m_cnt", 64'(cnt), m_busy ? 64'(exp_q[0].cnt) : 64'd0);
            if (m_busy) begin
                chk("m_addr", 64'(out_ab), 64'(exp_q[0].ab));
                chk("m_data", 64'(out_data), 64'(exp_q[0].data));
                chk("m_cid", 64'(out_cid), 64'(exp_q[0].cid));
                chk("m_mid", 64'(out_mid), 64'(exp_q[0].mid));
                chk("m_bi", 64'(out_bi), 64'(exp_q[0].bi));
                chk("m_gt", 64'(out_gt), 64'(exp_q[0].gt));
            end
            if (m_busy && out_ready) void'(exp_q.pop_front());
            if (in_valid && m_rdy) begin
                for (int k = 0; k < (in_hd ? RATIO : 1); k++) begin
                    nb.ab   = {in_ab, CNT_W'(k)};
                    nb.data = in_data[k*OUT_W +: OUT_W];
                    nb.cnt  = CNT_W'(k);
                    nb.last = (k == (in_hd ? RATIO : 1) - 1);
                    nb.cid  = in_cid;
                    nb.mid  = in_mid;
                    nb.bi   = in_bi;
                    nb.gt   = in_gt;
                    exp_q.push_back(nb);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [BEAT_W-1:0] ab, input logic cid,
                          input logic [MGR_W-1:0] mid, input logic bi, input logic [3:0] gt,
                          input logic hd, input logic [IN_W-1:0] d);
        in_valid = v; in_ab = ab; in_cid = cid; in_mid = mid;
        in_bi = bi; in_gt = gt; in_hd = hd; in_data = d;
    endtask

    logic [15:0] t1_exp [4];
    logic        pat [8];
    logic [63:0] cdat;
    int          hs;

    initial begin
        t1_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b0;
        set_in(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        out_ready = 1'b0;
        r1_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        tick;
        reset = 1'b1;

        // Four-beat data grant, free-running downstream.
        tick;
        set_in(1'b1, 3'd5, 1'b1, 2'd2, 1'b1, 4'h5, 1'b1, 64'h4444_3333_2222_1111);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_idle_ready", 64'(in_ready), 64'd1);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_data", 64'(out_data), 64'(t1_exp[k]));
            chk("t1_addr", 64'(out_ab), 64'h14 + 64'(k));
            chk("t1_done", 64'(done), 64'(k == 3));
            tick;
        end
        @(negedge clk);
        chk("t1_after_valid", 64'(out_valid), 64'd0);

        // Non-data ack grant.
        tick;
        set_in(1'b1, 3'd2, 1'b0, 2'd1, 1'b0, 4'h3, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_cnt", 64'(cnt), 64'd0);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_gt", 64'(out_gt), 64'h3);
        chk("t2_data", 64'(out_data), 64'hDDDD);
        chk("t2_addr", 64'(out_ab), 64'h08);
        tick;
        @(negedge clk);
        chk("t2_idle", 64'(out_valid), 64'd0);

        // Back-to-back bursts with no bubble.
        tick;
        set_in(1'b1, 3'd1, 1'b0, 2'd3, 1'b1, 4'h1, 1'b1, 64'h0123_4567_89AB_CDEF);
        tick;
        set_in(1'b1, 3'd2, 1'b1, 2'd0, 1'b0, 4'h2, 1'b1, 64'hFEDC_BA98_7654_3210);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t3_valid", 64'(out_valid), 64'd1);
            chk("t3_ready", 64'(in_ready), 64'(i == 4 || i == 8));
            tick;
            if (i == 4) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t3_idle", 64'(out_valid), 64'd0);

        // Downstream stalls mid-burst.
        tick;
        cdat = 64'hDEAD_BEEF_CAFE_F00D;
        set_in(1'b1, 3'd3, 1'b1, 2'd1, 1'b1, 4'h7, 1'b1, cdat);
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = pat[i];
            @(negedge clk);
            chk("t4_valid", 64'(out_valid), 64'd1);
            chk("t4_cnt", 64'(cnt), 64'(hs));
            chk("t4_data", 64'(out_data), 64'(cdat[hs*16 +: 16]));
            chk("t4_done", 64'(done), 64'(pat[i] && hs == 3));
            if (pat[i]) hs++;
            tick;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle", 64'(out_valid), 64'd0);

        // Asynchronous reset at cnt=2 drops the burst.
        tick;
        set_in(1'b1, 3'd6, 1'b0, 2'd2, 1'b1, 4'h4, 1'b1, 64'h8888_7777_6666_5555);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("t5_cnt_before", 64'(cnt), 64'd2);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_cnt", 64'(cnt), 64'd0);
        tick;
        tick;
        reset = 1'b1;
        tick;
        set_in(1'b1, 3'd7, 1'b1, 2'd3, 1'b1, 4'hC, 1'b1, 64'h9999_AAAA_BBBB_1234);
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_restart_cnt", 64'(cnt), 64'd0);
        chk("t5_restart_data", 64'(out_data), 64'h1234);
        chk("t5_restart_addr", 64'(out_ab), 64'h1C);
        repeat (4) tick;
        @(negedge clk);
        chk("t5_idle", 64'(out_valid), 64'd0);

        // RATIO=1 flow-through instance.
        tick;
        set_in(1'b1, 3'd5, 1'b1, 2'd3, 1'b1, 4'h9, 1'b1, 64'h0123_4567_89AB_CDEF);
        r1_out_ready = 1'b0;
        #1;
        chk("r1_in_ready", 64'(r1_in_ready), 64'd0);
        chk("r1_out_valid", 64'(r1_out_valid), 64'd1);
        chk("r1_cnt", 64'(r1_cnt), 64'd0);
        chk("r1_done", 64'(r1_done), 64'd1);
        chk("r1_data", r1_data, 64'h0123_4567_89AB_CDEF);
        chk("r1_addr", 64'(r1_ab), 64'hA);
        chk("r1_gt", 64'(r1_gt), 64'h9);
        r1_out_ready = 1'b1;
        #1;
        chk("r1_in_ready_hi", 64'(r1_in_ready), 64'd1);
        in_valid = 1'b0;
        #1;
        chk("r1_out_valid_lo", 64'(r1_out_valid), 64'd0);
        repeat (6) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
